// File: rtl/ng_par_seq.sv
// ng_par_seq: sequencer/arbiter for the parity generator/checker datapath.
// Two requesters share one datapath: memory-read check (MRD) and memory-write
// generate (MWR). The block runs a fixed pulse sequence per operation, samples
// the datapath parity-fail line, counts reported failures and raises a sticky
// restart request once the count reaches ALM_THRESH.
// Optional build macro: PAR_SEQ_RETRY_EN (one retry of a failing read test).
//
// Handshake: MRD_REQ/MWR_REQ are levels held by the requester until the
// matching DONE pulse; DONE is a single-cycle completion strobe, CHK_FAIL is
// only meaningful while MRD_DONE is high, and a requester may drop its request
// at any time without aborting an operation already granted.
module ng_par_seq #(
   parameter int ALM_THRESH = 4,
   parameter int CNT_W      = 8
) (
   input  logic             CLK2,
   input  logic             GENRST,
   input  logic             MRD_REQ,
   input  logic             MWR_REQ,
   output logic             MRD_DONE,
   output logic             MWR_DONE,
   output logic             CHK_FAIL,
   input  logic             PAR_FAIL_IN,
   output logic             CP_WP,
   output logic             CP_WP2,
   output logic             CP_RP2,
   output logic             CP_GP,
   output logic             CP_TP,
   output logic             CP_WE,
   output logic             CLR_PAR_ALM,
   input  logic             ALM_ACK,
   output logic [CNT_W-1:0] FAIL_CNT,
   output logic             RESTART,
   output logic [3:0]       dbg_state
);

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      R_LDP = 4'd1,
      R_TST = 4'd2,
      R_END = 4'd3,
      W_LDP = 4'd4,
      W_SV2 = 4'd5,
      W_GEN = 4'd6,
      W_WRT = 4'd7,
      W_END = 4'd8
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] THRESH  = CNT_W'(ALM_THRESH);

   state_t           state;
   logic             last_mwr;   // 1: the most recent grant went to MWR
   logic             cnt_inc;
   logic [CNT_W-1:0] cnt_next;
`ifdef PAR_SEQ_RETRY_EN
   logic             retried;    // the current read has already used its retry
`endif

   assign dbg_state = state;

   // Next failure count: acknowledge clears and beats a simultaneous increment.
   always_comb begin
      cnt_inc  = (state == R_END) && CHK_FAIL;
      cnt_next = FAIL_CNT;
      if (ALM_ACK) begin
         cnt_next = '0;
      end else if (cnt_inc && (FAIL_CNT != CNT_MAX)) begin
         cnt_next = FAIL_CNT + CNT_ONE;
      end
   end

   // Sequencer FSM with registered control pulses, failure counter and restart flag.
   always_ff @(posedge CLK2) begin
      if (GENRST) begin
         state       <= IDLE;
         last_mwr    <= 1'b1;
         CP_WP       <= 1'b0;
         CP_WP2      <= 1'b0;
         CP_RP2      <= 1'b0;
         CP_GP       <= 1'b0;
         CP_TP       <= 1'b0;
         CP_WE       <= 1'b0;
         MRD_DONE    <= 1'b0;
         MWR_DONE    <= 1'b0;
         CHK_FAIL    <= 1'b0;
         CLR_PAR_ALM <= 1'b0;
         FAIL_CNT    <= '0;
         RESTART     <= 1'b0;
`ifdef PAR_SEQ_RETRY_EN
         retried     <= 1'b0;
`endif
      end else begin
         // Pulses are one cycle wide: everything returns to idle unless set below.
         CP_WP       <= 1'b0;
         CP_WP2      <= 1'b0;
         CP_RP2      <= 1'b0;
         CP_GP       <= 1'b0;
         CP_TP       <= 1'b0;
         CP_WE       <= 1'b0;
         MRD_DONE    <= 1'b0;
         MWR_DONE    <= 1'b0;
         CHK_FAIL    <= 1'b0;
         CLR_PAR_ALM <= 1'b1;
         FAIL_CNT    <= cnt_next;
         RESTART     <= ALM_ACK ? 1'b0 : (RESTART | (cnt_next >= THRESH));

         case (state)
            IDLE: begin
               // Round-robin on a tie: MRD wins unless it was granted last.
               if (MRD_REQ && (!MWR_REQ || last_mwr)) begin
                  state    <= R_LDP;
                  CP_WP    <= 1'b1;
                  last_mwr <= 1'b0;
`ifdef PAR_SEQ_RETRY_EN
                  retried  <= 1'b0;
`endif
               end else if (MWR_REQ) begin
                  state    <= W_LDP;
                  CP_WP    <= 1'b1;
                  last_mwr <= 1'b1;
               end
            end
            R_LDP: begin
               state <= R_TST;
               CP_TP <= 1'b1;
            end
            R_TST: begin
`ifdef PAR_SEQ_RETRY_EN
               if (PAR_FAIL_IN && !retried) begin
                  state   <= R_LDP;
                  CP_WP   <= 1'b1;
                  retried <= 1'b1;
               end else begin
                  state    <= R_END;
                  MRD_DONE <= 1'b1;
                  CHK_FAIL <= PAR_FAIL_IN;
               end
`else
               state    <= R_END;
               MRD_DONE <= 1'b1;
               CHK_FAIL <= PAR_FAIL_IN;
`endif
            end
            R_END: begin
               state <= IDLE;
               if (CHK_FAIL) begin
                  CLR_PAR_ALM <= 1'b0;
               end
            end
            W_LDP: begin
               state  <= W_SV2;
               CP_WP2 <= 1'b1;
            end
            W_SV2: begin
               state  <= W_GEN;
               CP_GP  <= 1'b1;
               CP_RP2 <= 1'b1;
            end
            W_GEN: begin
               state <= W_WRT;
               CP_WE <= 1'b1;
            end
            W_WRT: begin
               state    <= W_END;
               MWR_DONE <= 1'b1;
            end
            W_END: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ng_par_seq.sv
// Self-checking bench for ng_par_seq. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle after the active edge.
module tb_ng_par_seq;

   logic       CLK2 = 1'b0;
   logic       GENRST, MRD_REQ, MWR_REQ, PAR_FAIL_IN, ALM_ACK;
   logic       MRD_DONE, MWR_DONE, CHK_FAIL;
   logic       CP_WP, CP_WP2, CP_RP2, CP_GP, CP_TP, CP_WE;
   logic       CLR_PAR_ALM, RESTART;
   logic [7:0] FAIL_CNT;
   logic [3:0] dbg_state;

   int n_pass  = 0;
   int n_total = 0;
   int model_cnt;
   bit model_rst;
   int clr_low_cnt;
   logic [8:0] exp_q[$];

   // Output mask layout: {MRD_DONE, MWR_DONE, CHK_FAIL, WP, WP2, RP2, GP, TP, WE}
   localparam logic [8:0] M_RDONE = 9'b100000000;
   localparam logic [8:0] M_WDONE = 9'b010000000;
   localparam logic [8:0] M_CHK   = 9'b001000000;
   localparam logic [8:0] M_WP    = 9'b000100000;
   localparam logic [8:0] M_WP2   = 9'b000010000;
   localparam logic [8:0] M_RP2   = 9'b000001000;
   localparam logic [8:0] M_GP    = 9'b000000100;
   localparam logic [8:0] M_TP    = 9'b000000010;
   localparam logic [8:0] M_WE    = 9'b000000001;
`ifdef PAR_SEQ_RETRY_EN
   localparam int RD_FAIL_LAT = 5;
`else
   localparam int RD_FAIL_LAT = 3;
`endif

   typedef struct {
      bit         is_wr;
      logic [1:0] fpat;      // bit0: first test result, bit1: retry test result
      int         exp_lat;
      logic       exp_chk;
      int         exp_cnt;
      logic       exp_rst;
   } vec_t;

   vec_t vecs[6];

   ng_par_seq #(.ALM_THRESH(4), .CNT_W(8)) dut (
      .CLK2(CLK2), .GENRST(GENRST), .MRD_REQ(MRD_REQ), .MWR_REQ(MWR_REQ),
      .MRD_DONE(MRD_DONE), .MWR_DONE(MWR_DONE), .CHK_FAIL(CHK_FAIL),
      .PAR_FAIL_IN(PAR_FAIL_IN), .CP_WP(CP_WP), .CP_WP2(CP_WP2), .CP_RP2(CP_RP2),
      .CP_GP(CP_GP), .CP_TP(CP_TP), .CP_WE(CP_WE), .CLR_PAR_ALM(CLR_PAR_ALM),
      .ALM_ACK(ALM_ACK), .FAIL_CNT(FAIL_CNT), .RESTART(RESTART), .dbg_state(dbg_state)
   );

   // Clock
   always #5 CLK2 = ~CLK2;

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [8:0] cur_mask();
      return {MRD_DONE, MWR_DONE, CHK_FAIL, CP_WP, CP_WP2, CP_RP2, CP_GP, CP_TP, CP_WE};
   endfunction

   // Reference: expected per-cycle pulse list of one operation, returns the reported failure.
   function automatic logic build_trace(input bit is_wr, input logic [1:0] fpat);
      logic fails;
      int   tests;
      exp_q.delete();
      if (is_wr) begin
         exp_q.push_back(M_WP);
         exp_q.push_back(M_WP2);
         exp_q.push_back(M_GP | M_RP2);
         exp_q.push_back(M_WE);
         exp_q.push_back(M_WDONE);
         return 1'b0;
      end
`ifdef PAR_SEQ_RETRY_EN
      tests = fpat[0] ? 2 : 1;
      fails = fpat[0] & fpat[1];
`else
      tests = 1;
      fails = fpat[0];
`endif
      for (int t = 0; t < tests; t++) begin
         exp_q.push_back(M_WP);
         exp_q.push_back(M_TP);
      end
      exp_q.push_back(fails ? (M_RDONE | M_CHK) : M_RDONE);
      return fails;
   endfunction

   // Reference: saturating counter and sticky restart, acknowledge takes priority.
   function automatic void model_update(input logic fail, input bit ack);
      if (ack) begin
         model_cnt = 0;
         model_rst = 1'b0;
      end else begin
         if (fail && model_cnt < 255) model_cnt++;
         if (model_cnt >= 4) model_rst = 1'b1;
      end
   endfunction

   task automatic do_reset();
      GENRST = 1'b1; MRD_REQ = 1'b0; MWR_REQ = 1'b0; PAR_FAIL_IN = 1'b0; ALM_ACK = 1'b0;
      @(negedge CLK2);
      @(negedge CLK2);
      check("rst_pulses", 32'(cur_mask()), 32'd0);
      check("rst_clr_low", 32'(CLR_PAR_ALM), 32'd0);
      check("rst_cnt", 32'(FAIL_CNT), 32'd0);
      check("rst_restart", 32'(RESTART), 32'd0);
      GENRST = 1'b0;
      @(negedge CLK2);
      check("rst_clr_high", 32'(CLR_PAR_ALM), 32'd1);
      model_cnt = 0;
      model_rst = 1'b0;
   endtask

   // One operation from IDLE, including the IDLE cycle that follows DONE.
   task automatic do_op(input bit is_wr, input logic [1:0] fpat, input bit ack,
                        input bit drop_early, output int lat, output logic chk);
      logic       exp_chk;
      logic [8:0] m;
      int         tp_seen;
      bit         done;
      exp_chk = build_trace(is_wr, fpat);
      tp_seen = 0; done = 1'b0; lat = -1; chk = 1'b0;
      PAR_FAIL_IN = 1'b0;
      if (is_wr) MWR_REQ = 1'b1; else MRD_REQ = 1'b1;
      for (int i = 1; i <= 12 && !done; i++) begin
         @(negedge CLK2);
         m = cur_mask();
         if (exp_q.size() != 0) check("trace", 32'(m), 32'(exp_q.pop_front()));
         else check("trace_over", 32'(m), 32'd0);
         if (drop_early && i == 1) begin
            MRD_REQ = 1'b0; MWR_REQ = 1'b0;
         end
         if (CP_TP) begin
            PAR_FAIL_IN = (tp_seen > 0) ? fpat[1] : fpat[0];
            tp_seen++;
         end else begin
            PAR_FAIL_IN = 1'b0;
         end
         if (MRD_DONE || MWR_DONE) begin
            done = 1'b1; lat = i; chk = CHK_FAIL;
            MRD_REQ = 1'b0; MWR_REQ = 1'b0;
            ALM_ACK = ack;
         end
      end
      check("done_seen", 32'(done), 32'd1);
      MRD_REQ = 1'b0; MWR_REQ = 1'b0;
      model_update(exp_chk, ack);
      @(negedge CLK2);
      ALM_ACK = 1'b0; PAR_FAIL_IN = 1'b0;
      if (CLR_PAR_ALM === 1'b0) clr_low_cnt++;
      check("idle_pulses", 32'(cur_mask()), 32'd0);
      check("clr_par_alm", 32'(CLR_PAR_ALM), 32'(!exp_chk));
      check("fail_cnt", 32'(FAIL_CNT), 32'(model_cnt));
      check("restart", 32'(RESTART), 32'(model_rst));
   endtask

   initial begin
      int   lat;
      logic chk;
      int   seen, dones;
      bit   found;
      int   order[4];
      int   when[4];
      int   arb_exp[4];

      vecs[0] = '{is_wr: 1'b0, fpat: 2'b00, exp_lat: 3,           exp_chk: 1'b0, exp_cnt: 0, exp_rst: 1'b0};
      vecs[1] = '{is_wr: 1'b1, fpat: 2'b00, exp_lat: 5,           exp_chk: 1'b0, exp_cnt: 0, exp_rst: 1'b0};
      vecs[2] = '{is_wr: 1'b0, fpat: 2'b11, exp_lat: RD_FAIL_LAT, exp_chk: 1'b1, exp_cnt: 1, exp_rst: 1'b0};
      vecs[3] = '{is_wr: 1'b1, fpat: 2'b11, exp_lat: 5,           exp_chk: 1'b0, exp_cnt: 1, exp_rst: 1'b0};
      vecs[4] = '{is_wr: 1'b0, fpat: 2'b11, exp_lat: RD_FAIL_LAT, exp_chk: 1'b1, exp_cnt: 2, exp_rst: 1'b0};
      vecs[5] = '{is_wr: 1'b0, fpat: 2'b00, exp_lat: 3,           exp_chk: 1'b0, exp_cnt: 2, exp_rst: 1'b0};
      arb_exp = '{0, 1, 0, 1};
      clr_low_cnt = 0;

      do_reset();

      // Table-driven single operations
      for (int v = 0; v < 6; v++) begin
         do_op(vecs[v].is_wr, vecs[v].fpat, 1'b0, 1'b0, lat, chk);
         check("tbl_latency", 32'(lat), 32'(vecs[v].exp_lat));
         check("tbl_chk_fail", 32'(chk), 32'(vecs[v].exp_chk));
         check("tbl_fail_cnt", 32'(FAIL_CNT), 32'(vecs[v].exp_cnt));
         check("tbl_restart", 32'(RESTART), 32'(vecs[v].exp_rst));
      end

      // Request dropped right after grant still completes
      do_op(1'b0, 2'b00, 1'b0, 1'b1, lat, chk);
      check("drop_latency", 32'(lat), 32'd3);

      // Reset while in W_GEN aborts the write with no DONE and clears the count
      MWR_REQ = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge CLK2);
         if (CP_GP) found = 1'b1;
      end
      check("wgen_reached", 32'(found), 32'd1);
      GENRST = 1'b1; MWR_REQ = 1'b0;
      @(negedge CLK2);
      check("wgen_rst_pulses", 32'(cur_mask()), 32'd0);
      check("wgen_rst_clr", 32'(CLR_PAR_ALM), 32'd0);
      check("wgen_rst_cnt", 32'(FAIL_CNT), 32'd0);
      GENRST = 1'b0;
      model_cnt = 0; model_rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK2);
         if (MWR_DONE || MRD_DONE) dones++;
      end
      check("wgen_no_done", 32'(dones), 32'd0);
      do_op(1'b1, 2'b00, 1'b0, 1'b0, lat, chk);
      check("wgen_rewrite_lat", 32'(lat), 32'd5);

      // Both requests held: round-robin MRD, MWR, MRD, MWR with only the IDLE gap
      do_reset();
      MRD_REQ = 1'b1; MWR_REQ = 1'b1;
      seen = 0;
      order = '{-1, -1, -1, -1};
      when  = '{0, 0, 0, 0};
      for (int c = 1; c <= 80 && seen < 4; c++) begin
         @(negedge CLK2);
         if (MRD_DONE) begin order[seen] = 0; when[seen] = c; seen++; end
         else if (MWR_DONE) begin order[seen] = 1; when[seen] = c; seen++; end
         if (seen == 4) begin MRD_REQ = 1'b0; MWR_REQ = 1'b0; end
      end
      MRD_REQ = 1'b0; MWR_REQ = 1'b0;
      check("arb_count", 32'(seen), 32'd4);
      for (int k = 0; k < 4; k++) check("arb_order", 32'(order[k]), 32'(arb_exp[k]));
      check("arb_gap_rd_wr", 32'(when[1] - when[0]), 32'd6);
      check("arb_gap_wr_rd", 32'(when[2] - when[1]), 32'd4);
      check("arb_gap_rd_wr2", 32'(when[3] - when[2]), 32'd6);
      @(negedge CLK2);
      check("arb_idle", 32'(cur_mask()), 32'd0);

      // Four failing reads reach the threshold, then acknowledge
      do_reset();
      clr_low_cnt = 0;
      for (int k = 0; k < 4; k++) do_op(1'b0, 2'b11, 1'b0, 1'b0, lat, chk);
      check("thr_clr_pulses", 32'(clr_low_cnt), 32'd4);
      check("thr_cnt", 32'(FAIL_CNT), 32'd4);
      check("thr_restart", 32'(RESTART), 32'd1);
      ALM_ACK = 1'b1;
      @(negedge CLK2);
      ALM_ACK = 1'b0;
      model_update(1'b0, 1'b1);
      check("ack_cnt", 32'(FAIL_CNT), 32'd0);
      check("ack_restart", 32'(RESTART), 32'd0);

      // Acknowledge coinciding with an increment wins
      do_op(1'b0, 2'b11, 1'b0, 1'b0, lat, chk);
      do_op(1'b0, 2'b11, 1'b1, 1'b0, lat, chk);
      check("ack_wins_cnt", 32'(FAIL_CNT), 32'd0);

`ifdef PAR_SEQ_RETRY_EN
      // Fail then pass on retry: no report, no count, longer latency
      do_op(1'b0, 2'b11, 1'b0, 1'b0, lat, chk);
      do_op(1'b0, 2'b01, 1'b0, 1'b0, lat, chk);
      check("retry_latency", 32'(lat), 32'd5);
      check("retry_chk", 32'(chk), 32'd0);
      check("retry_cnt", 32'(FAIL_CNT), 32'd1);
      check("retry_clr", 32'(CLR_PAR_ALM), 32'd1);
`endif

      // Saturation of the failure counter
      do_reset();
      for (int k = 0; k < 258; k++) do_op(1'b0, 2'b11, 1'b0, 1'b0, lat, chk);
      check("sat_cnt", 32'(FAIL_CNT), 32'd255);
      check("sat_restart", 32'(RESTART), 32'd1);

      // Randomized operations against the reference model
      do_reset();
      for (int k = 0; k < 150; k++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) @(negedge CLK2);
         do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0), lat, chk);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
